// File: rtl/mac_accumulator_if.sv
// Issue/result handshake bundle for mac_accumulator: operand-issue tags, multiplier
// product, completed-group output stream and the sticky error flag.
interface mac_accumulator_if;
  logic        issue_valid;
  logic        issue_last;
  logic        issue_ready;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [8:0]  out_count;
  logic        err;

  modport master (
    output issue_valid, issue_last, product, out_ready,
    input  issue_ready, out_valid, out_sum, out_count, err
  );

  modport slave (
    input  issue_valid, issue_last, product, out_ready,
    output issue_ready, out_valid, out_sum, out_count, err
  );
endinterface

// File: rtl/mac_accumulator.sv
// Accumulates products from a fixed-latency upstream multiplier into per-group sums
// and queues completed {sum, count} entries in a small FIFO with registered outputs.
module mac_accumulator #(
  parameter int MUL_LATENCY = 3,
  parameter int FIFO_DEPTH  = 2,
  parameter int MAX_TERMS   = 256
) (
  input logic              clock,
  input logic              reset_n,
  mac_accumulator_if.slave bus
);

  localparam int SUM_W = 32;
  localparam int CNT_W = 9;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TERMS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  function automatic logic [LAT_W-1:0] count_lasts(
    input logic [MUL_LATENCY-1:0] v,
    input logic [MUL_LATENCY-1:0] l
  );
    logic [LAT_W-1:0] n;
    n = {LAT_W{1'b0}};
    for (int i = 0; i < MUL_LATENCY; i++) begin
      n = n + LAT_W'(v[i] & l[i]);
    end
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1'b1);
  endfunction

  logic [MUL_LATENCY-1:0] tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic [SUM_W-1:0]       acc_q, acc_d, sum_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic                   d_valid_s, d_last_s, forced_s, close_s;

  logic [SUM_W-1:0]       mem_sum_q [FIFO_DEPTH];
  logic [CNT_W-1:0]       mem_cnt_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   pop_s, push_ok_s, drop_s;

  logic                   out_valid_q, out_valid_d;
  logic [SUM_W-1:0]       out_sum_q, out_sum_d;
  logic [CNT_W-1:0]       out_count_q, out_count_d;
  logic                   err_q, err_d;
  logic                   issue_ready_q, issue_ready_d;

  // Tag pipeline: stage k holds the issue made k+1 cycles ago; a last is only meaningful with valid.
  always_comb begin
    tag_v_d    = {MUL_LATENCY{1'b0}};
    tag_l_d    = {MUL_LATENCY{1'b0}};
    tag_v_d[0] = bus.issue_valid;
    tag_l_d[0] = bus.issue_valid & bus.issue_last;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
  end

  // Group accumulation on the delayed tag, closing on last or on reaching MAX_TERMS.
  always_comb begin
    d_valid_s = tag_v_q[MUL_LATENCY-1];
    d_last_s  = tag_l_q[MUL_LATENCY-1];
    sum_s     = acc_q + {16'd0, bus.product};
    cnt_inc_s = cnt_q + 9'd1;
    forced_s  = d_valid_s & ~d_last_s & (cnt_inc_s == MAX_CNT);
    close_s   = d_valid_s & (d_last_s | forced_s);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (close_s) begin
      acc_d = {SUM_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else if (d_valid_s) begin
      acc_d = sum_s;
      cnt_d = cnt_inc_s;
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head pops in the same cycle.
  always_comb begin
    pop_s     = out_valid_q & bus.out_ready;
    push_ok_s = close_s & ((occ_q != FULL_OCC) | pop_s);
    drop_s    = close_s & ~push_ok_s;
    wr_ptr_d  = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1'b1);
      2'b01:   occ_d = occ_q - OCC_W'(1'b1);
      default: occ_d = occ_q;
    endcase
  end

  // Next head entry: the incoming push bypasses storage when it lands in the head slot.
  always_comb begin
    out_valid_d = 1'b0;
    out_sum_d   = {SUM_W{1'b0}};
    out_count_d = {CNT_W{1'b0}};
    if (occ_d == {OCC_W{1'b0}}) begin
      out_valid_d = 1'b0;
    end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_s;
      out_count_d = cnt_inc_s;
    end else begin
      out_valid_d = 1'b1;
      out_sum_d   = mem_sum_q[rd_ptr_d];
      out_count_d = mem_cnt_q[rd_ptr_d];
    end
  end

  // Flow control and sticky error; ready reserves a slot for every last still in flight.
  always_comb begin
    err_d         = err_q | (bus.issue_valid & ~issue_ready_q) | forced_s | drop_s;
    issue_ready_d = (int'(occ_d) + int'(count_lasts(tag_v_d, tag_l_d))) < FIFO_DEPTH;
  end

  // State registers; reset discards in-flight tags and any partial group.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_q       <= {MUL_LATENCY{1'b0}};
      tag_l_q       <= {MUL_LATENCY{1'b0}};
      acc_q         <= {SUM_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      occ_q         <= {OCC_W{1'b0}};
      out_valid_q   <= 1'b0;
      out_sum_q     <= {SUM_W{1'b0}};
      out_count_q   <= {CNT_W{1'b0}};
      err_q         <= 1'b0;
      issue_ready_q <= 1'b1;
    end else begin
      tag_v_q       <= tag_v_d;
      tag_l_q       <= tag_l_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_count_q   <= out_count_d;
      err_q         <= err_d;
      issue_ready_q <= issue_ready_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_sum_q[i] <= {SUM_W{1'b0}};
        mem_cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_sum_q[wr_ptr_q] <= sum_s;
      mem_cnt_q[wr_ptr_q] <= cnt_inc_s;
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum     = out_sum_q;
  assign bus.out_count   = out_count_q;
  assign bus.err         = err_q;

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
- REQ-001: Parameter MUL_LATENCY SHALL default to 3; cycles from operand issue to product on the upstream multiplier's result.
- REQ-002: Parameter FIFO_DEPTH SHALL default to 2; number of completed-sum entries buffered.
- REQ-003: Parameter MAX_TERMS SHALL default to 256; maximum products per group.
- REQ-004: clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset_n  input  1  asynchronous, active-low reset.
- REQ-006: issue_valid  input  1  an operand pair enters the multiplier this cycle.
- REQ-007: issue_last  input  1  the issued pair is the final term of its group; ignored when issue_valid=0.
- REQ-008: issue_ready  output  1  upstream may assert issue_valid this cycle.
- REQ-009: product  input  16  multiplier result, unsigned.
- REQ-010: out_valid  output  1  head FIFO entry is valid.
- REQ-011: out_ready  input  1  downstream accepts head entry.
- REQ-012: out_sum  output  32  group sum of the head entry.
- REQ-013: out_count  output  9  number of terms in the head entry, 1..256.
- REQ-014: err  output  1  sticky protocol/length error flag.

Function
- REQ-015: A MUL_LATENCY-stage tag pipeline SHALL carry {issue_valid, issue_last}; a term issued in cycle t SHALL be accumulated using product sampled in cycle t+MUL_LATENCY.
- REQ-016: Accumulation SHALL be acc <= acc + zero-extended product, cnt <= cnt + 1, on each delayed valid tag; no wrap is possible within MAX_TERMS.
- REQ-017: On a delayed valid tag with last=1, {acc+product, cnt+1} SHALL be pushed to the FIFO and acc, cnt cleared in the same edge; the next term starts a fresh group with no bubble.
- REQ-018: A group containing a single term SHALL push {product, 1}.
- REQ-019: On the delayed term that brings cnt to MAX_TERMS without last, the group SHALL be closed and pushed as if last, and err set.
- REQ-020: issue_ready SHALL be 1 iff (fifo_count + lasts in tag pipeline) < FIFO_DEPTH, so every push has space.
- REQ-021: An issue with issue_ready=0 SHALL still be tracked and accumulated, set err, and its push dropped if the FIFO is full at push time.
- REQ-022: FIFO pop SHALL occur when out_valid && out_ready; out_sum/out_count SHALL hold steady while out_valid && !out_ready.
- REQ-023: Simultaneous push and pop SHALL be legal at any occupancy, including full; count unchanged.
- REQ-024: Push into an empty FIFO SHALL make out_valid=1 the following cycle (registered output, one-cycle latency).
- REQ-025: When empty, out_valid SHALL be 0; out_sum/out_count SHALL be 0.
- REQ-026: err SHALL remain set until reset.

Reset
- REQ-027: Assertion of reset_n=0 SHALL immediately clear the tag pipeline, acc, cnt, FIFO, and err, independent of clock.
- REQ-028: During reset, out_valid=0, out_sum=0, out_count=0, err=0, issue_ready=1.
- REQ-029: Reset mid-group SHALL discard the partial sum and in-flight tags; products arriving after deassertion without a matching post-reset tag SHALL be ignored.

Verification
- REQ-030: Issue 4 terms with products 3,5,7,11 (last on 4th), out_ready=1 -> one entry out_sum=26, out_count=4, out_valid at cycle t_last+MUL_LATENCY+1.
- REQ-031: Back-to-back single-term groups of products 1,2,3 with out_ready=0 -> issue_ready drops after 2 lasts are in flight or stored; FIFO holds {1,1},{2,1}; err=0; after out_ready=1 both pop in order.
- REQ-032: Full FIFO with out_ready=1 and a push in the same cycle -> pop and push both occur, occupancy stays 2, no err.
- REQ-033: 256 terms of product 0xFFFF, no last -> entry out_sum=0x00FFFF00, out_count=256, err=1.
- REQ-034: Assert reset_n=0 after 2 of 4 terms -> outputs clear asynchronously; after release, group 10,20 (last) -> out_sum=30, out_count=2.
- REQ-035: issue_valid while issue_ready=0 with FIFO full -> err=1, FIFO contents unchanged.
